// File: rtl/ram_bus_bridge_pkg.sv
// rtl/ram_bus_bridge_pkg.sv - shared types and constants for the RAM bus bridge
package bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        GAP,
        WR,
        RESP
    } state_e;

    localparam logic [3:0]  FULL_STRB         = 4'b1111;
    localparam logic [3:0]  READ_STRB         = 4'b0000;
    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/ram_bus_bridge_if.sv
// rtl/ram_bus_bridge_if.sv - CPU native memory port and single-port RAM port bundles
interface mem_bus_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        bus_error;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, bus_error
    );
    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, bus_error
    );
endinterface

interface ram_bus_if;
    logic        ram_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_rdata;
    logic        ram_ready;

    modport master (
        output ram_en, ram_addr, ram_wdata, ram_wstrb,
        input  ram_rdata, ram_ready
    );
    modport slave (
        input  ram_en, ram_addr, ram_wdata, ram_wstrb,
        output ram_rdata, ram_ready
    );
endinterface

// File: rtl/ram_bus_bridge_rmw_byte_merge.sv
// rtl/ram_bus_bridge_rmw_byte_merge.sv - per-lane merge of strobed bytes into an old word
module rmw_byte_merge (
    input  logic [31:0] old_word_i,
    input  logic [31:0] new_word_i,
    input  logic [3:0]  strb_i,
    output logic [31:0] merged_o
);

    always_comb begin
        merged_o = old_word_i;
        for (int i = 0; i < 4; i++) begin
            if (strb_i[i]) begin
                merged_o[8*i +: 8] = new_word_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ram_bus_bridge.sv
// rtl/ram_bus_bridge.sv - PicoRV32 memory port to single-port RAM bridge with RMW and timeout
module ram_bus_bridge
    import bridge_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          RAM_WORDS = 1024,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic      clk,
    input  logic      resetn,
    mem_bus_if.slave  mem,
    ram_bus_if.master ram
);

    localparam logic [31:0] WIN_BYTES = 32'(RAM_WORDS * 4);
    localparam int          CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_e        state_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [CW-1:0] cnt_q;
    logic          mem_ready_q;
    logic [31:0]   mem_rdata_q;
    logic          bus_error_q;
    logic          ram_en_q;
    logic [31:0]   ram_addr_q;
    logic [31:0]   ram_wdata_q;
    logic [3:0]    ram_wstrb_q;

    logic [31:0]   offset_d;
    logic          in_window_d;
    logic [31:0]   merged_d;

    assign offset_d    = mem.mem_addr - ADDR_BASE;
    assign in_window_d = offset_d < WIN_BYTES;

    rmw_byte_merge u_merge (
        .old_word_i (ram.ram_rdata),
        .new_word_i (wdata_q),
        .strb_i     (wstrb_q),
        .merged_o   (merged_d)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cnt_q       <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= '0;
            bus_error_q <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_wstrb_q <= '0;
        end else begin
            mem_ready_q <= 1'b0;
            bus_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem.mem_valid && !mem_ready_q) begin
                        wdata_q    <= mem.mem_wdata;
                        wstrb_q    <= mem.mem_wstrb;
                        ram_addr_q <= offset_d;
                        cnt_q      <= '0;
                        if (!in_window_d) begin
                            mem_rdata_q <= '0;
                            bus_error_q <= 1'b1;
                            mem_ready_q <= 1'b1;
                            state_q     <= RESP;
                        end else if (mem.mem_wstrb == FULL_STRB) begin
                            ram_en_q    <= 1'b1;
                            ram_wstrb_q <= FULL_STRB;
                            ram_wdata_q <= mem.mem_wdata;
                            state_q     <= WR;
                        end else begin
                            ram_en_q    <= 1'b1;
                            ram_wstrb_q <= READ_STRB;
                            state_q     <= RD;
                        end
                    end
                end
                RD: begin
                    if (ram.ram_ready) begin
                        ram_en_q <= 1'b0;
                        if (wstrb_q == READ_STRB) begin
                            mem_rdata_q <= ram.ram_rdata;
                            mem_ready_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            ram_wdata_q <= merged_d;
                            state_q     <= GAP;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        // A stalled read aborts the whole RMW; the write phase never starts.
                        ram_en_q    <= 1'b0;
                        mem_rdata_q <= ERR_RDATA;
                        bus_error_q <= 1'b1;
                        mem_ready_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                GAP: begin
                    ram_en_q    <= 1'b1;
                    ram_wstrb_q <= FULL_STRB;
                    cnt_q       <= '0;
                    state_q     <= WR;
                end
                WR: begin
                    if (ram.ram_ready || cnt_q == TO_LAST) begin
                        ram_en_q    <= 1'b0;
                        ram_wstrb_q <= READ_STRB;
                        mem_rdata_q <= ram.ram_ready ? 32'h0 : ERR_RDATA;
                        bus_error_q <= !ram.ram_ready;
                        mem_ready_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem.mem_ready = mem_ready_q;
    assign mem.mem_rdata = mem_rdata_q;
    assign mem.bus_error = bus_error_q;
    assign ram.ram_en    = ram_en_q;
    assign ram.ram_addr  = ram_addr_q;
    assign ram.ram_wdata = ram_wdata_q;
    assign ram.ram_wstrb = ram_wstrb_q;

endmodule

// File: tb/tb_ram_bus_bridge.sv
// tb/tb_ram_bus_bridge.sv - scoreboard bench for ram_bus_bridge against a word-array RAM model
module tb_ram_bus_bridge;

    localparam int          RAM_WORDS = 1024;
    localparam int          TIMEOUT   = 255;
    localparam logic [31:0] ERR_WORD  = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_bus_if mif ();
    ram_bus_if rif ();

    ram_bus_bridge #(
        .ADDR_BASE (32'h0000_0000),
        .RAM_WORDS (RAM_WORDS),
        .TIMEOUT   (TIMEOUT),
        .ERR_RDATA (ERR_WORD)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .mem    (mif.slave),
        .ram    (rif.master)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model[RAM_WORDS];
    logic [31:0] ram_arr[RAM_WORDS];
    int          tests = 0;
    int          fails = 0;
    int          en_cycles = 0;
    bit          stall = 1'b0;
    bit          rand_delay = 1'b0;
    bit          init_req = 1'b1;
    int          delay_cnt, delay_tgt;
    logic        prev_en = 1'b0;
    logic [31:0] prev_addr, prev_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RAM behaves as: ready <= en & !ready, optionally delayed or stalled forever.
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < RAM_WORDS; i++) ram_arr[i] <= model[i];
            rif.ram_ready <= 1'b0;
            rif.ram_rdata <= '0;
            delay_cnt     <= 0;
            delay_tgt     <= 0;
        end else if (rif.ram_en && !rif.ram_ready && !stall) begin
            if (delay_cnt < delay_tgt) begin
                delay_cnt <= delay_cnt + 1;
            end else begin
                rif.ram_ready <= 1'b1;
                rif.ram_rdata <= ram_arr[rif.ram_addr[11:2]];
                if (rif.ram_wstrb == 4'hF) ram_arr[rif.ram_addr[11:2]] <= rif.ram_wdata;
                delay_cnt <= 0;
                delay_tgt <= rand_delay ? int'($urandom_range(0, 3)) : 0;
            end
        end else begin
            rif.ram_ready <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (rif.ram_en) begin
                en_cycles++;
                check("ram_wstrb_legal", 32'(rif.ram_wstrb == 4'h0 || rif.ram_wstrb == 4'hF), 32'd1);
            end
            if (rif.ram_en && prev_en) begin
                check("ram_addr_stable", rif.ram_addr, prev_addr);
                check("ram_wdata_stable", rif.ram_wdata, prev_wdata);
            end
            if (mif.mem_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_mem_ready: got response with empty scoreboard, expected none");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("mem_rdata", mif.mem_rdata, e.rdata);
                    check("bus_error", 32'(mif.bus_error), 32'(e.err));
                end
            end
        end
        prev_en    = rif.ram_en;
        prev_addr  = rif.ram_addr;
        prev_wdata = rif.ram_wdata;
    end

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                             input int exp_lat, input int exp_en, input string tag);
        exp_t e;
        int   lat;
        bit   done;
        int   idx;
        idx = int'(addr[11:2]);
        if (addr >= 32'(RAM_WORDS * 4)) begin
            e.rdata = '0; e.err = 1'b1;
        end else if (stall) begin
            e.rdata = ERR_WORD; e.err = 1'b1;
        end else if (strb == 4'h0) begin
            e.rdata = model[idx]; e.err = 1'b0;
        end else begin
            model[idx] = (model[idx] & ~strb_mask(strb)) | (wdata & strb_mask(strb));
            e.rdata = '0; e.err = 1'b0;
        end
        sb.push_back(e);
        @(posedge clk); #1;
        mif.mem_valid = 1'b1;
        mif.mem_addr  = addr;
        mif.mem_wdata = wdata;
        mif.mem_wstrb = strb;
        en_cycles     = 0;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 1000) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (mif.mem_ready) done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_no_response: got no mem_ready within %0d cycles, expected one", tag, lat);
        end
        if (exp_lat >= 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (exp_en >= 0)  check({tag, "_en_cycles"}, 32'(en_cycles), 32'(exp_en));
        @(posedge clk); #1;
        mif.mem_valid = 1'b0;
        mif.mem_wdata = $urandom;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_ready"}, 32'(mif.mem_ready), 32'd0);
        check({tag, "_mem_rdata"}, mif.mem_rdata, 32'd0);
        check({tag, "_bus_error"}, 32'(mif.bus_error), 32'd0);
        check({tag, "_ram_en"}, 32'(rif.ram_en), 32'd0);
        check({tag, "_ram_wstrb"}, 32'(rif.ram_wstrb), 32'd0);
        check({tag, "_ram_addr"}, rif.ram_addr, 32'd0);
        check({tag, "_ram_wdata"}, rif.ram_wdata, 32'd0);
    endtask

    initial begin
        resetn        = 1'b0;
        mif.mem_valid = 1'b0;
        mif.mem_addr  = '0;
        mif.mem_wdata = '0;
        mif.mem_wstrb = '0;
        for (int i = 0; i < RAM_WORDS; i++) model[i] = $urandom;
        model[4] = 32'h1234_5678;
        model[2] = 32'h1122_3344;
        repeat (3) @(posedge clk);
        init_req = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        resetn = 1'b1;

        do_access(32'h0000_0010, 32'h0,          4'b0000, 3, 2, "read_word4");
        do_access(32'h0000_0020, 32'hCAFE_BABE,  4'b1111, 3, 2, "full_write");
        do_access(32'h0000_0020, 32'h0,          4'b0000, 3, 2, "readback");
        do_access(32'h0000_0008, 32'hAABB_CCDD,  4'b0101, 6, 4, "partial_write");
        check("merged_word2", model[2], 32'h11BB_33DD);
        do_access(32'h0000_0008, 32'h0,          4'b0000, 3, 2, "read_merged");
        do_access(32'h0000_1000, 32'h0,          4'b0000, 1, 0, "out_of_window");
        do_access(32'hFFFF_FFFC, 32'h5555_5555,  4'b1111, 1, 0, "oow_write");

        stall = 1'b1;
        do_access(32'h0000_0010, 32'h0,          4'b0000, TIMEOUT + 1, TIMEOUT, "timeout_read");
        do_access(32'h0000_0008, 32'hFFFF_FFFF,  4'b0011, TIMEOUT + 1, TIMEOUT, "timeout_rmw");
        stall = 1'b0;
        do_access(32'h0000_0008, 32'h0,          4'b0000, 3, 2, "after_timeout");

        // Reset while the RMW sits in its gap cycle; the word must be left untouched.
        @(posedge clk); #1;
        mif.mem_valid = 1'b1;
        mif.mem_addr  = 32'h0000_0030;
        mif.mem_wdata = 32'h0F0F_0F0F;
        mif.mem_wstrb = 4'b0011;
        repeat (3) @(posedge clk);
        #1;
        check("gap_ram_en", 32'(rif.ram_en), 32'd0);
        resetn        = 1'b0;
        mif.mem_valid = 1'b0;
        @(posedge clk); #1;
        check_outputs_zero("gap_reset");
        resetn = 1'b1;
        do_access(32'h0000_0030, 32'h0, 4'b0000, 3, 2, "post_reset_read");

        rand_delay = 1'b1;
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            logic [3:0]  s;
            int          k;
            k = int'($urandom_range(0, 9));
            if (k == 0) a = 32'h0000_1000 | $urandom;
            else        a = {20'h0, 10'($urandom_range(0, 15)), 2'b00};
            k = int'($urandom_range(0, 2));
            s = (k == 0) ? 4'h0 : (k == 1) ? 4'hF : 4'($urandom_range(1, 14));
            do_access(a, $urandom, s, -1, -1, "random");
        end
        repeat (4) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_bus_bridge.md
Name: ram_bus_bridge

Overview:
- Sits between the PicoRV32 native memory port and the single-port simulation RAM.
- Decodes the RAM address window and sequences the RAM's enable/ready handshake, one access at a time.
- The RAM writes whole words only, so the bridge turns partial-byte writes into read-modify-write.
- Out-of-window accesses and RAM stalls are completed with an error response, so the CPU never hangs.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte base address of the RAM window.
- RAM_WORDS, 1024, window size in 32-bit words; must be a power of two.
- TIMEOUT, 255, maximum cycles to wait for ram_ready in one RAM phase.
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on timeout.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- mem_valid  in  1  CPU request valid
- mem_ready  out  1  one-cycle completion pulse to CPU
- mem_addr  in  32  CPU byte address
- mem_wdata  in  32  CPU write data
- mem_wstrb  in  4  byte strobes; 0000 means read
- mem_rdata  out  32  read data, valid while mem_ready=1
- ram_en  out  1  RAM enable, held until ram_ready
- ram_addr  out  32  byte offset into window (mem_addr - ADDR_BASE)
- ram_wdata  out  32  full-word write data
- ram_wstrb  out  4  0000 or 1111 only
- ram_rdata  in  32  RAM read data, valid with ram_ready
- ram_ready  in  1  RAM ready (RAM registers ready <= en & !ready)
- bus_error  out  1  one-cycle pulse on decode error or timeout

Behaviour:
- Reset: clk is the clock; resetn is synchronous and active-low. Reset is dominant in any state. Reset values: state IDLE; mem_ready=0, mem_rdata=0, ram_en=0, ram_wstrb=0, ram_addr=0, ram_wdata=0, bus_error=0; timeout counter=0.
- All outputs are registered.
- States: IDLE, RD, GAP, WR, RESP.
- IDLE:
  - Triggers on mem_valid=1 and mem_ready=0. Latch addr/wdata/wstrb and compute offset = mem_addr - ADDR_BASE (32-bit wrap).
  - In window means offset < RAM_WORDS*4.
  - Out of window: go RESP with mem_rdata=0 and bus_error=1; no RAM access; mem_ready in cycle 1.
  - Read (wstrb=0000) or partial write: go RD; ram_en=1, ram_wstrb=0000.
  - Full write (wstrb=1111): go WR; ram_en=1, ram_wstrb=1111, ram_wdata=mem_wdata.
- RD:
  - Waits for ram_ready, then drops ram_en.
  - Read access: mem_rdata=ram_rdata, go RESP.
  - Partial write: merge per byte lane i (lane = strobe[i] ? wdata byte : ram_rdata byte) into ram_wdata, go GAP.
- GAP: one cycle with ram_en=0, so the RAM's ready flop clears; then go WR with ram_en=1, ram_wstrb=1111.
- WR: waits for ram_ready, drops ram_en and ram_wstrb to 0, goes RESP; mem_rdata=0.
- RESP: mem_ready=1 for exactly one cycle; bus_error is set only for error cases; next state IDLE.
- Latency (accept cycle = 0, mem_ready cycle with an ideal RAM): read 3, full write 3, partial write 6, decode error 1.
- Timeout:
  - The counter clears on entering RD/WR and increments each cycle without ram_ready.
  - When it reaches TIMEOUT: ram_en=0, mem_rdata=ERR_RDATA, bus_error=1, go RESP. For RMW, the write phase is skipped.
- mem_valid is ignored during mem_ready=1 and in every non-IDLE state. A request is never re-accepted in the same cycle it completes.
- ram_ready seen outside RD/WR is ignored.
- ram_addr and ram_wdata stay stable while ram_en=1.

Decomposition:
- Shared package bridge_pkg holds:
  - state enum (IDLE, RD, GAP, WR, RESP);
  - constants FULL_STRB=4'b1111 and READ_STRB=4'b0000;
  - ERR_RDATA default.
- One combinational sub-module, rmw_byte_merge: inputs old word, new word, strobes; output merged word.
- FSM and timeout counter stay in the top level.

Test Plan:
- Read addr 0x10, RAM word[4]=0x12345678 -> ram_en high cycles 1-2; mem_ready cycle 3 with mem_rdata=0x12345678; bus_error=0.
- Full write 0xCAFEBABE to 0x20, wstrb=1111 -> single ram_en phase with ram_wstrb=1111; mem_ready cycle 3; readback returns 0xCAFEBABE.
- Partial write, word[2]=0x11223344, wdata=0xAABBCCDD, wstrb=0101 -> read phase, ram_en=0 at cycle 3, write of 0x11BB33DD; mem_ready cycle 6.
- Read addr 0x0000_1000 (outside 1024 words) -> mem_ready cycle 1, rdata=0, bus_error pulse, ram_en never asserted.
- Hold ram_ready=0 -> after 255 waiting cycles: ram_en drops, mem_rdata=0xDEADBEEF, bus_error=1 on the mem_ready cycle.
- Assert resetn=0 during GAP of an RMW -> next cycle all outputs 0, state IDLE; the following read completes normally in 3 cycles.
